// File: rtl/rvee_fetch_queue.sv
// Instruction fetch unit: PC generation, up to DEPTH outstanding AXI4-lite reads, and an
// in-order instruction queue feeding decode. Redirects flush the queue and drop stale beats.
module rvee_fetch_queue #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   resetv,
  input  logic              jmp,
  input  logic [XLEN-1:0]   jmp_target,
  output logic              arvalid,
  input  logic              arready,
  output logic [AWIDTH-1:0] araddr,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DWIDTH-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              f_valid,
  input  logic              f_ready,
  output logic [31:0]       f_iw,
  output logic [XLEN-1:0]   f_pc,
  output logic              f_err,
  output logic              f_flush
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            arvalid_q, arvalid_d;
  logic            stale_q, stale_d;
  logic            flush_q;
  cnt_t            inflight_q, inflight_d;
  cnt_t            drop_q, drop_d;
  cnt_t            count_q, count_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            pc_rd_q, pc_rd_d;
  ptr_t            pc_wr_q, pc_wr_d;
  logic [CW:0]     reserved;

  logic [31:0]     iw_q  [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic            err_q [DEPTH];
  // PCs of accepted reads, consumed in order as their R beats return
  logic [XLEN-1:0] pcf_q [DEPTH];

  logic ar_hs, r_hs, push, pop;

  assign ar_hs = arvalid_q & arready;
  // A beat with nothing outstanding is a protocol violation; ignoring it keeps counters sane.
  assign r_hs  = rvalid & (inflight_q != '0);
  assign push  = r_hs & ~jmp & (drop_q == '0);
  assign pop   = f_valid & f_ready & ~jmp;

  always_comb begin
    inflight_d = inflight_q + cnt_t'(ar_hs) - cnt_t'(r_hs);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (jmp) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    pc_wr_d = ar_hs ? pc_wr_q + ptr_t'(1) : pc_wr_q;
    pc_rd_d = r_hs  ? pc_rd_q + ptr_t'(1) : pc_rd_q;

    // Every read still outstanding after a redirect belongs to the old stream. A request
    // pending across the redirect joins the drop count once it is accepted.
    if (jmp) begin
      drop_d  = inflight_d;
      stale_d = arvalid_q & ~arready;
    end else begin
      drop_d = drop_q;
      if (r_hs && (drop_q != '0)) drop_d = drop_d - cnt_t'(1);
      if (ar_hs && stale_q)       drop_d = drop_d + cnt_t'(1);
      stale_d = stale_q & ~ar_hs;
    end

    // A stale pending request must not advance fpc, which already holds the target.
    if (jmp) begin
      fpc_d = {jmp_target[XLEN-1:2], 2'b00};
    end else if (ar_hs && !stale_q) begin
      fpc_d = fpc_q + XLEN'(4);
    end else begin
      fpc_d = fpc_q;
    end

    reserved = {1'b0, inflight_d} + {1'b0, count_d};
    if (arvalid_q && !arready) begin
      arvalid_d = 1'b1;
      addr_d    = addr_q;
    end else begin
      arvalid_d = (reserved < DepthW);
      addr_d    = fpc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= resetv;
      addr_q     <= resetv;
      arvalid_q  <= 1'b0;
      stale_q    <= 1'b0;
      flush_q    <= 1'b0;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pc_rd_q    <= '0;
      pc_wr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        iw_q[i]  <= '0;
        pc_q[i]  <= '0;
        err_q[i] <= 1'b0;
        pcf_q[i] <= '0;
      end
    end else begin
      fpc_q      <= fpc_d;
      addr_q     <= addr_d;
      arvalid_q  <= arvalid_d;
      stale_q    <= stale_d;
      flush_q    <= jmp;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_rd_q    <= pc_rd_d;
      pc_wr_q    <= pc_wr_d;
      if (ar_hs) pcf_q[pc_wr_q] <= addr_q;
      if (push) begin
        iw_q[wr_ptr_q]  <= rdata[31:0];
        pc_q[wr_ptr_q]  <= pcf_q[pc_rd_q];
        err_q[wr_ptr_q] <= (rresp != 2'b00);
      end
    end
  end

  assign arvalid = arvalid_q;
  assign araddr  = AWIDTH'(addr_q);
  assign arprot  = 3'b100;
  assign rready  = 1'b1;
  assign f_valid = (count_q != '0);
  assign f_iw    = iw_q[rd_ptr_q];
  assign f_pc    = pc_q[rd_ptr_q];
  assign f_err   = err_q[rd_ptr_q];
  assign f_flush = flush_q;

  a_no_orphan_r: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (inflight_q != '0));

  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  a_no_overcommit: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, inflight_q} + {1'b0, count_q}) <= DepthW));

endmodule

// File: doc/rvee_fetch_queue.md
Name: rvee_fetch_queue

Overview:
Parametrised next-generation instruction fetch unit. It merges PC generation and fetch into one block, and keeps up to DEPTH AXI4-lite instruction reads in flight. Returned words go into a DEPTH-entry instruction queue that feeds decode. On a redirect (jump), the queue is flushed and stale in-flight responses are discarded without stalling the AXI protocol.

Parameters:
AWIDTH, 32, AXI address width
DWIDTH, 32, AXI data width; only 32 is legal (one instruction per beat)
XLEN, 32, PC width
DEPTH, 4, queue entries and max outstanding reads; power of 2, minimum 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
resetv  in  XLEN  fetch start address, sampled while rst is high
jmp  in  1  redirect request, single-cycle pulse
jmp_target  in  XLEN  redirect address; bits [1:0] are ignored (forced to 0)
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
araddr  out  AWIDTH  read address (zero-extended or truncated from the PC)
arprot  out  3  constant 3'b100 (instruction, secure, unprivileged)
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
rdata  in  DWIDTH  instruction word
rresp  in  2  response code
f_valid  out  1  queue head valid
f_ready  in  1  decode accepts the head
f_iw  out  32  head instruction word
f_pc  out  XLEN  head PC
f_err  out  1  head fetch returned rresp != 0
f_flush  out  1  one-cycle pulse, the cycle after a jmp is taken

Behaviour:
- State: fetch PC (fpc); queue with rd/wr pointers (DEPTH entries of iw, pc, err); inflight counter and drop counter, each clog2(DEPTH)+1 bits.
- Reset values:
  - fpc = resetv; queue empty; inflight = drop = 0.
  - arvalid = 0, araddr = resetv, rready = 1, f_valid = 0, f_iw = 0, f_pc = 0, f_err = 0, f_flush = 0.
- Issue:
  - arvalid is set when no request is pending and (inflight + occupancy) < DEPTH.
  - Once set, arvalid and araddr hold stable until arready. Deasserting arvalid before the handshake is forbidden, including on a jmp.
  - On the AR handshake: fpc += 4 (wraps modulo 2^XLEN) and inflight += 1.
  - First arvalid appears in the first clk edge after rst deasserts.
- Response:
  - rready is tied to 1. Space is reserved at issue, so overflow is impossible.
  - On an R handshake: inflight -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise push {rdata, pc, rresp != 0}. The pc is tracked in a parallel PC FIFO written at AR handshake.
  - Error responses are queued, not retried.
- Output:
  - f_valid = queue not empty; f_iw, f_pc and f_err come from registered head storage.
  - Pop when f_valid && f_ready.
  - Minimum latency: the R handshake in cycle N makes f_valid high in cycle N+1.
  - The head is stable while f_valid && !f_ready.
- Jump (jmp high at edge E):
  - fpc = jmp_target & ~3.
  - Queue is cleared; the PC FIFO keeps only entries for requests that will be dropped.
  - drop = inflight after this cycle's AR/R updates, including an AR accepted at E, an AR still pending (counted when accepted), and excluding an R consumed at E.
  - f_flush = 1 for the cycle after E.
  - An R handshake or pop in the same cycle as jmp is discarded.
  - A pending unaccepted AR completes at the old address and is marked dropped. The first request to the target issues after that handshake.
  - Back-to-back jmp: the last one wins; drop accumulates correctly.
- Boundaries:
  - Queue full with inflight = 0 means no issue.
  - Occupancy + inflight never exceeds DEPTH.
  - Counters never underflow; an rvalid with inflight = 0 is a protocol violation, checked by assertion.
- rst asserted mid-operation clears everything asynchronously. Outstanding AXI transactions are the interconnect's responsibility, since it shares the reset.

Test Plan:
- Reset release, resetv=0x1000, arready=1, single-cycle memory returning addr-derived words, f_ready=1 -> araddr sequence 0x1000, 0x1004, 0x1008…; f_pc matches araddr order; f_iw correct.
- DEPTH=4, f_ready=0, arready=1, rvalid=1 -> exactly 4 AR handshakes, then arvalid=0; queue full; asserting f_ready resumes issue one request per pop.
- Memory latency 5 cycles, 3 reads outstanding, jmp to 0x2002 -> f_flush pulses 1 cycle later; 3 stale R beats are dropped; next araddr = 0x2000; first f_pc = 0x2000.
- jmp while arvalid=1, arready=0 -> arvalid and araddr hold; after the handshake the response is dropped; the following araddr is the target.
- rresp=2'b10 on the word for PC 0x1004 -> f_err=1 only for that head entry; subsequent words have f_err=0.
- Async rst pulse mid-burst (not aligned to clk) -> outputs return to reset values immediately; fetch restarts at resetv.
